fractal_sync_rf_port_sched: RTL and testbench
=============================================

// Module: fractal_sync_rf_port_sched
// PURPOSE
//  Shares the N_PORTS check ports of a fractal-sync 1D local register file among N_REQ synch. requesters.
//  Round-robin grants up to N_PORTS valid requesters per cycle and drives the RF ports combinationally.
//  Captures the RF results (present/sd/id_err/bypass/ignore) into a per-requester response register.
//  Holds each response until the requester accepts it. Sits directly in front of one 1D local RF instance.
// PARAMETERS
//  ID_WIDTH  1   width of barrier id (matches RF ID_WIDTH)
//  SD_WIDTH  fractal_sync_pkg::SD_WIDTH (localparam)   source/destination field width
//  N_REQ     4   number of requesters; N_REQ >= N_PORTS
//  N_PORTS   2   number of RF check ports; >= 2
// PORTS
//  clk_i          in   1                 clock
//  rst_i          in   1                 synchronous active-high reset
//  req_valid_i    in   1 [N_REQ]         requester has a synch. request
//  req_ready_o    out  1 [N_REQ]         request granted this cycle (handshake completes)
//  req_id_i       in   ID_WIDTH [N_REQ]  barrier id
//  req_sd_i       in   SD_WIDTH [N_REQ]  source of request
//  rsp_valid_o    out  1 [N_REQ]         response held for requester
//  rsp_ready_i    in   1 [N_REQ]         requester accepts response
//  rsp_present_o  out  1 [N_REQ]         RF reported barrier present
//  rsp_sd_o       out  SD_WIDTH [N_REQ]  destination returned by RF
//  rsp_id_err_o   out  1 [N_REQ]         RF reported invalid id
//  rsp_bypass_o   out  1 [N_REQ]         RF reported bypass
//  rsp_ignore_o   out  1 [N_REQ]         RF reported ignore
//  rf_id_o        out  ID_WIDTH [N_PORTS] id to RF port
//  rf_check_o     out  1 [N_PORTS]       check strobe to RF port
//  rf_sd_o        out  SD_WIDTH [N_PORTS] source to RF port
//  rf_present_i / rf_sd_i / rf_id_err_i / rf_bypass_i / rf_ignore_i  in  [N_PORTS]  RF results, same cycle
// BEHAVIOUR
//  Reset (rst_i=1 at posedge): all rsp_* regs 0, all per-requester FSMs IDLE, rr pointer 0. Outputs req_ready_o,
//   rf_check_o are combinational and 0 during reset cycle; rf_id_o/rf_sd_o 0 on unused ports.
//  Per-requester FSM: IDLE -> (granted) -> PEND -> (rsp_valid_o & rsp_ready_i) -> IDLE. rsp_valid_o = (state==PEND).
//  Eligible(r) = req_valid_i[r] & state[r]==IDLE. Requester completing response handshake this cycle is NOT eligible
//   until next cycle (max throughput per requester: 1 request / 2 cycles).
//  Arbitration (comb): scan r = ptr, ptr+1, ... mod N_REQ; k-th eligible found (k<N_PORTS) gets port k.
//   Port order preserves scan order so RF bypass/ignore priority follows round-robin order.
//  req_ready_o[r]=1 iff granted; grant depends on req_valid_i (valid->ready comb path allowed, never ready->valid).
//  Port k granted: rf_check_o[k]=1, rf_id_o[k]=req_id_i[r], rf_sd_o[k]=req_sd_i[r]; ungranted port: all 0.
//  Posedge after grant: rsp_* of r <= rf_*_i[k]; state PEND. Latency req handshake -> rsp_valid_o = 1 cycle.
//  rsp_* fields stable while PEND; cleared to 0 on return to IDLE.
//  Pointer: if >=1 grant, ptr <= (last granted index + 1) mod N_REQ; if no grant, ptr unchanged. Wraps at N_REQ-1.
//  Fewer eligible than ports: remaining ports idle. More eligible: excess wait; no requester waits > ceil(N_REQ/N_PORTS) grant rounds.
//  Reset mid-operation: pending responses discarded without rsp handshake; requesters must reissue.
//  Pointer width: N_REQ>1 ? $clog2(N_REQ) : 1. Elaboration asserts N_PORTS>=2, N_REQ>=N_PORTS.
// TESTING
//  N_REQ=4,N_PORTS=2. Reset, no valids -> rf_check_o all 0, rsp_valid_o all 0, ptr 0.
//  All 4 valid, ids 2,4,6,8 -> cycle0 grants r0->port0,r1->port1; ptr=2; cycle1 r2,r3 granted; rsp_valid r0,r1 in cycle1.
//  r0,r1 valid same id=6, rf_bypass_i[0]=1, rf_ignore_i[1]=1 -> rsp_bypass_o[0]=1, rsp_ignore_o[1]=1 next cycle.
//  r1 PEND with rsp_ready_i=0 for 5 cycles, req_valid_i[1]=1 -> no re-grant of r1, rsp fields stable; ready=1 -> IDLE, re-grant following cycle.
//  ptr=3, r3 and r0 valid -> r3->port0, r0->port1, ptr wraps to 1.
//  Assert rst_i while r0,r2 PEND -> next cycle rsp_valid_o all 0, ptr 0; r2 then regrantable immediately.

Source files
------------

// File: rtl/fractal_sync_rf_port_sched.sv
// Round-robin scheduler sharing N_PORTS check ports of a fractal-sync 1D local RF among N_REQ requesters.
// Each requester gets a one-entry response register that is held until the requester accepts it.
module fractal_sync_rf_port_sched #(
    parameter int ID_WIDTH = 1,
    parameter int SD_WIDTH = 2,
    parameter int N_REQ    = 4,
    parameter int N_PORTS  = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [N_REQ-1:0]                   req_valid_i,
    output logic [N_REQ-1:0]                   req_ready_o,
    input  logic [N_REQ-1:0][ID_WIDTH-1:0]     req_id_i,
    input  logic [N_REQ-1:0][SD_WIDTH-1:0]     req_sd_i,
    output logic [N_REQ-1:0]                   rsp_valid_o,
    input  logic [N_REQ-1:0]                   rsp_ready_i,
    output logic [N_REQ-1:0]                   rsp_present_o,
    output logic [N_REQ-1:0][SD_WIDTH-1:0]     rsp_sd_o,
    output logic [N_REQ-1:0]                   rsp_id_err_o,
    output logic [N_REQ-1:0]                   rsp_bypass_o,
    output logic [N_REQ-1:0]                   rsp_ignore_o,
    output logic [N_PORTS-1:0][ID_WIDTH-1:0]   rf_id_o,
    output logic [N_PORTS-1:0]                 rf_check_o,
    output logic [N_PORTS-1:0][SD_WIDTH-1:0]   rf_sd_o,
    input  logic [N_PORTS-1:0]                 rf_present_i,
    input  logic [N_PORTS-1:0][SD_WIDTH-1:0]   rf_sd_i,
    input  logic [N_PORTS-1:0]                 rf_id_err_i,
    input  logic [N_PORTS-1:0]                 rf_bypass_i,
    input  logic [N_PORTS-1:0]                 rf_ignore_i
);

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PORT_W = $clog2(N_PORTS);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    generate
        if (N_PORTS < 2 || N_REQ < N_PORTS) begin : g_param_err
            $error("fractal_sync_rf_port_sched: need N_PORTS >= 2 and N_REQ >= N_PORTS");
        end
    endgenerate

    logic [N_REQ-1:0]                 state_q, state_d;
    logic [PTR_W-1:0]                 ptr_q, ptr_d;
    logic [N_REQ-1:0]                 present_q, present_d;
    logic [N_REQ-1:0][SD_WIDTH-1:0]   sd_q, sd_d;
    logic [N_REQ-1:0]                 id_err_q, id_err_d;
    logic [N_REQ-1:0]                 bypass_q, bypass_d;
    logic [N_REQ-1:0]                 ignore_q, ignore_d;

    logic [N_REQ-1:0]                 gnt;
    logic [N_REQ-1:0][PORT_W-1:0]     gnt_port;
    logic [PTR_W-1:0]                 last_gnt;

    // Scan from the pointer; the k-th eligible requester gets port k so RF priority follows rr order.
    always_comb begin
        int cnt;
        int idx;
        gnt      = '0;
        gnt_port = '0;
        last_gnt = ptr_q;
        cnt      = 0;
        idx      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!rst_i && req_valid_i[idx] && state_q[idx] == IDLE && cnt < N_PORTS) begin
                gnt[idx]      = 1'b1;
                gnt_port[idx] = PORT_W'(cnt);
                last_gnt      = PTR_W'(idx);
                cnt           = cnt + 1;
            end
        end
    end

    always_comb begin
        rf_check_o = '0;
        rf_id_o    = '0;
        rf_sd_o    = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (gnt[r]) begin
                rf_check_o[gnt_port[r]] = 1'b1;
                rf_id_o[gnt_port[r]]    = req_id_i[r];
                rf_sd_o[gnt_port[r]]    = req_sd_i[r];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (|gnt) begin
            ptr_d = (last_gnt == PTR_W'(N_REQ - 1)) ? '0 : last_gnt + PTR_W'(1);
        end
    end

    // A requester finishing its response handshake stays PEND this cycle, so it cannot be re-granted until next.
    always_comb begin
        state_d   = state_q;
        present_d = present_q;
        sd_d      = sd_q;
        id_err_d  = id_err_q;
        bypass_d  = bypass_q;
        ignore_d  = ignore_q;
        for (int r = 0; r < N_REQ; r++) begin
            if (gnt[r]) begin
                state_d[r]   = PEND;
                present_d[r] = rf_present_i[gnt_port[r]];
                sd_d[r]      = rf_sd_i[gnt_port[r]];
                id_err_d[r]  = rf_id_err_i[gnt_port[r]];
                bypass_d[r]  = rf_bypass_i[gnt_port[r]];
                ignore_d[r]  = rf_ignore_i[gnt_port[r]];
            end else if (state_q[r] == PEND && rsp_ready_i[r]) begin
                state_d[r]   = IDLE;
                present_d[r] = 1'b0;
                sd_d[r]      = '0;
                id_err_d[r]  = 1'b0;
                bypass_d[r]  = 1'b0;
                ignore_d[r]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= '0;
            ptr_q     <= '0;
            present_q <= '0;
            sd_q      <= '0;
            id_err_q  <= '0;
            bypass_q  <= '0;
            ignore_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            present_q <= present_d;
            sd_q      <= sd_d;
            id_err_q  <= id_err_d;
            bypass_q  <= bypass_d;
            ignore_q  <= ignore_d;
        end
    end

    assign req_ready_o   = gnt;
    assign rsp_valid_o   = state_q;
    assign rsp_present_o = present_q;
    assign rsp_sd_o      = sd_q;
    assign rsp_id_err_o  = id_err_q;
    assign rsp_bypass_o  = bypass_q;
    assign rsp_ignore_o  = ignore_q;

endmodule

// File: tb/tb_fractal_sync_rf_port_sched.sv
// Bench for fractal_sync_rf_port_sched: directed scenarios plus random traffic against a queue-based
// reference model of the round-robin port sharing and response holding.
module tb_fractal_sync_rf_port_sched;

    localparam int NR = 4;
    localparam int NP = 2;
    localparam int IW = 4;
    localparam int SW = 4;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [NR-1:0]          req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
    logic [NR-1:0]          rsp_present_o, rsp_id_err_o, rsp_bypass_o, rsp_ignore_o;
    logic [NR-1:0][IW-1:0]  req_id_i;
    logic [NR-1:0][SW-1:0]  req_sd_i, rsp_sd_o;
    logic [NP-1:0][IW-1:0]  rf_id_o;
    logic [NP-1:0]          rf_check_o;
    logic [NP-1:0][SW-1:0]  rf_sd_o, rf_sd_i;
    logic [NP-1:0]          rf_present_i, rf_id_err_i, rf_bypass_i, rf_ignore_i;

    int n_vec = 0;
    int n_mis = 0;

    fractal_sync_rf_port_sched #(
        .ID_WIDTH(IW), .SD_WIDTH(SW), .N_REQ(NR), .N_PORTS(NP)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_id_i(req_id_i), .req_sd_i(req_sd_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_present_o(rsp_present_o), .rsp_sd_o(rsp_sd_o),
        .rsp_id_err_o(rsp_id_err_o), .rsp_bypass_o(rsp_bypass_o), .rsp_ignore_o(rsp_ignore_o),
        .rf_id_o(rf_id_o), .rf_check_o(rf_check_o), .rf_sd_o(rf_sd_o),
        .rf_present_i(rf_present_i), .rf_sd_i(rf_sd_i), .rf_id_err_i(rf_id_err_i),
        .rf_bypass_i(rf_bypass_i), .rf_ignore_i(rf_ignore_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: pending flag and held response per requester, plus the round-robin start index.
    logic [NR-1:0]          m_pend, m_pres, m_err, m_byp, m_ign;
    logic [NR-1:0][SW-1:0]  m_sd;
    int                     m_ptr = 0;

    logic [NR-1:0]          e_ready;
    logic [NP-1:0]          e_check;
    logic [NP-1:0][IW-1:0]  e_rf_id;
    logic [NP-1:0][SW-1:0]  e_rf_sd;
    int                     e_port [NR];
    int                     e_last;
    bit                     e_any;

    function automatic void model_eval();
        int q[$];
        e_ready = '0;
        e_check = '0;
        e_rf_id = '0;
        e_rf_sd = '0;
        e_any   = 1'b0;
        e_last  = m_ptr;
        for (int r = 0; r < NR; r++) e_port[r] = 0;
        if (rst_i !== 1'b1) begin
            for (int i = 0; i < NR; i++) begin
                int r;
                r = (m_ptr + i) % NR;
                if (req_valid_i[r] && !m_pend[r]) q.push_back(r);
            end
        end
        for (int k = 0; k < NP && k < q.size(); k++) begin
            e_ready[q[k]] = 1'b1;
            e_port[q[k]]  = k;
            e_check[k]    = 1'b1;
            e_rf_id[k]    = req_id_i[q[k]];
            e_rf_sd[k]    = req_sd_i[q[k]];
            e_last        = q[k];
            e_any         = 1'b1;
        end
    endfunction

    always @(posedge clk_i) begin
        model_eval();
        if (rst_i) begin
            m_pend <= '0; m_pres <= '0; m_sd <= '0; m_err <= '0; m_byp <= '0; m_ign <= '0;
            m_ptr  <= 0;
        end else begin
            for (int r = 0; r < NR; r++) begin
                if (e_ready[r]) begin
                    m_pend[r] <= 1'b1;
                    m_pres[r] <= rf_present_i[e_port[r]];
                    m_sd[r]   <= rf_sd_i[e_port[r]];
                    m_err[r]  <= rf_id_err_i[e_port[r]];
                    m_byp[r]  <= rf_bypass_i[e_port[r]];
                    m_ign[r]  <= rf_ignore_i[e_port[r]];
                end else if (m_pend[r] && rsp_ready_i[r]) begin
                    m_pend[r] <= 1'b0; m_pres[r] <= 1'b0; m_sd[r] <= '0;
                    m_err[r]  <= 1'b0; m_byp[r]  <= 1'b0; m_ign[r] <= 1'b0;
                end
            end
            if (e_any) m_ptr <= (e_last + 1) % NR;
        end
    end

    task automatic rand_rf();
        rf_present_i = NP'($urandom);
        rf_sd_i      = (NP*SW)'($urandom);
        rf_id_err_i  = NP'($urandom);
        rf_bypass_i  = NP'($urandom);
        rf_ignore_i  = NP'($urandom);
    endtask

    task automatic rand_req();
        req_id_i = (NR*IW)'($urandom);
        req_sd_i = (NR*SW)'($urandom);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        rst_i = 1'b0; req_valid_i = '0; rsp_ready_i = '1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_valid_i = '1; rsp_ready_i = '0;
        rand_req(); rand_rf();
        step();
        for (int c = 0; c < 2; c++) begin
            rand_rf();
            #3;
            n_vec++;
            if (req_ready_o !== '0 || rf_check_o !== '0) begin
                n_mis++;
                $display("FAIL reset_comb cyc%0d: ready=%b check=%b, required 0000/00", c, req_ready_o, rf_check_o);
            end
            n_vec++;
            if (rsp_valid_o !== '0 || rf_id_o !== '0 || rf_sd_o !== '0) begin
                n_mis++;
                $display("FAIL reset_state cyc%0d: rsp_valid=%b rf_id=%h rf_sd=%h, required zeros", c, rsp_valid_o, rf_id_o, rf_sd_o);
            end
            step();
        end
        rst_i = 1'b0; req_valid_i = '0;
        #3;
        model_eval();
        n_vec++;
        if (rf_check_o !== '0 || rsp_valid_o !== '0) begin
            n_mis++;
            $display("FAIL reset_idle: check=%b rsp_valid=%b, required 00/0000", rf_check_o, rsp_valid_o);
        end
        step();
    endtask

    task automatic test_all_valid();
        req_valid_i = '1; rsp_ready_i = '0;
        req_id_i = {4'd8, 4'd6, 4'd4, 4'd2};
        rand_rf();
        #3;
        model_eval();
        n_vec++;
        if (req_ready_o !== 4'b0011 || rf_id_o !== {4'd4, 4'd2}) begin
            n_mis++;
            $display("FAIL all_valid_c0: ready=%b rf_id=%h, required 0011/42", req_ready_o, rf_id_o);
        end
        n_vec++;
        if ({req_ready_o, rf_check_o, rf_id_o, rf_sd_o} !== {e_ready, e_check, e_rf_id, e_rf_sd}) begin
            n_mis++;
            $display("FAIL all_valid_port0: got %h, model %h", {req_ready_o, rf_check_o, rf_id_o, rf_sd_o}, {e_ready, e_check, e_rf_id, e_rf_sd});
        end
        step();
        rand_rf();
        #3;
        model_eval();
        n_vec++;
        if (req_ready_o !== 4'b1100 || rsp_valid_o !== 4'b0011 || rf_id_o !== {4'd8, 4'd6}) begin
            n_mis++;
            $display("FAIL all_valid_c1: ready=%b rsp_valid=%b rf_id=%h, required 1100/0011/86", req_ready_o, rsp_valid_o, rf_id_o);
        end
        n_vec++;
        if ({rsp_valid_o, rsp_present_o, rsp_sd_o, rsp_id_err_o, rsp_bypass_o, rsp_ignore_o} !== {m_pend, m_pres, m_sd, m_err, m_byp, m_ign}) begin
            n_mis++;
            $display("FAIL all_valid_rsp: got %h, model %h", {rsp_valid_o, rsp_present_o, rsp_sd_o, rsp_id_err_o, rsp_bypass_o, rsp_ignore_o}, {m_pend, m_pres, m_sd, m_err, m_byp, m_ign});
        end
        step();
        drain();
    endtask

    task automatic test_bypass_ignore();
        req_valid_i = 4'b0011; rsp_ready_i = '0;
        rand_req();
        req_id_i[0] = 4'd6; req_id_i[1] = 4'd6;
        rand_rf();
        rf_bypass_i = 2'b01; rf_ignore_i = 2'b10;
        #3;
        n_vec++;
        if (rf_id_o !== {4'd6, 4'd6} || rf_check_o !== 2'b11) begin
            n_mis++;
            $display("FAIL byp_ign_port: rf_id=%h check=%b, required 66/11", rf_id_o, rf_check_o);
        end
        step();
        req_valid_i = '0;
        rand_rf();
        #3;
        n_vec++;
        if ({rsp_bypass_o[1:0], rsp_ignore_o[1:0]} !== 4'b0110 || rsp_valid_o !== 4'b0011) begin
            n_mis++;
            $display("FAIL byp_ign_rsp: byp=%b ign=%b valid=%b, required 01/10/0011", rsp_bypass_o[1:0], rsp_ignore_o[1:0], rsp_valid_o);
        end
        n_vec++;
        if ({rsp_valid_o, rsp_present_o, rsp_sd_o, rsp_id_err_o, rsp_bypass_o, rsp_ignore_o} !== {m_pend, m_pres, m_sd, m_err, m_byp, m_ign}) begin
            n_mis++;
            $display("FAIL byp_ign_model: got %h, model %h", {rsp_valid_o, rsp_present_o, rsp_sd_o, rsp_id_err_o, rsp_bypass_o, rsp_ignore_o}, {m_pend, m_pres, m_sd, m_err, m_byp, m_ign});
        end
        step();
        drain();
    endtask

    task automatic test_hold();
        req_valid_i = 4'b0010; rsp_ready_i = '0;
        rand_req(); rand_rf();
        step();
        for (int c = 0; c < 5; c++) begin
            rand_req(); rand_rf();
            #3;
            n_vec++;
            if (req_ready_o !== '0 || rsp_valid_o !== 4'b0010) begin
                n_mis++;
                $display("FAIL hold_c%0d: ready=%b rsp_valid=%b, required 0000/0010", c, req_ready_o, rsp_valid_o);
            end
            n_vec++;
            if ({rsp_present_o, rsp_sd_o, rsp_id_err_o, rsp_bypass_o, rsp_ignore_o} !== {m_pres, m_sd, m_err, m_byp, m_ign}) begin
                n_mis++;
                $display("FAIL hold_fields_c%0d: got %h, model %h", c, {rsp_present_o, rsp_sd_o, rsp_id_err_o, rsp_bypass_o, rsp_ignore_o}, {m_pres, m_sd, m_err, m_byp, m_ign});
            end
            step();
        end
        rsp_ready_i = 4'b0010;
        #3;
        n_vec++;
        if (req_ready_o !== '0) begin
            n_mis++;
            $display("FAIL hold_accept: ready=%b, required 0000", req_ready_o);
        end
        step();
        rsp_ready_i = '0;
        #3;
        n_vec++;
        if (req_ready_o !== 4'b0010 || rsp_valid_o !== '0) begin
            n_mis++;
            $display("FAIL hold_regrant: ready=%b rsp_valid=%b, required 0010/0000", req_ready_o, rsp_valid_o);
        end
        step();
        drain();
    endtask

    task automatic test_wrap();
        req_valid_i = 4'b0100; rsp_ready_i = '0;
        rand_req(); rand_rf();
        step();
        req_valid_i = '0; rsp_ready_i = '1;
        step();
        req_valid_i = 4'b1001; rsp_ready_i = '0;
        rand_req(); rand_rf();
        #3;
        n_vec++;
        if (req_ready_o !== 4'b1001 || rf_id_o !== {req_id_i[0], req_id_i[3]} || rf_sd_o !== {req_sd_i[0], req_sd_i[3]}) begin
            n_mis++;
            $display("FAIL wrap_order: ready=%b rf_id=%h rf_sd=%h, required 1001/%h/%h", req_ready_o, rf_id_o, rf_sd_o, {req_id_i[0], req_id_i[3]}, {req_sd_i[0], req_sd_i[3]});
        end
        step();
        req_valid_i = '1;
        rand_req(); rand_rf();
        #3;
        n_vec++;
        if (req_ready_o !== 4'b0110 || rf_id_o !== {req_id_i[2], req_id_i[1]}) begin
            n_mis++;
            $display("FAIL wrap_ptr1: ready=%b rf_id=%h, required 0110/%h", req_ready_o, rf_id_o, {req_id_i[2], req_id_i[1]});
        end
        step();
        drain();
    endtask

    task automatic test_reset_mid();
        req_valid_i = 4'b0101; rsp_ready_i = '0;
        rand_req(); rand_rf();
        #3;
        n_vec++;
        if (req_ready_o !== 4'b0101) begin
            n_mis++;
            $display("FAIL rstmid_grant: ready=%b, required 0101", req_ready_o);
        end
        step();
        rst_i = 1'b1; req_valid_i = 4'b0100;
        #3;
        n_vec++;
        if (req_ready_o !== '0 || rf_check_o !== '0 || rsp_valid_o !== 4'b0101) begin
            n_mis++;
            $display("FAIL rstmid_during: ready=%b check=%b rsp_valid=%b, required 0000/00/0101", req_ready_o, rf_check_o, rsp_valid_o);
        end
        step();
        rst_i = 1'b0;
        #3;
        n_vec++;
        if (rsp_valid_o !== '0 || req_ready_o !== 4'b0100 || rf_check_o !== 2'b01 || rf_id_o[0] !== req_id_i[2]) begin
            n_mis++;
            $display("FAIL rstmid_after: rsp_valid=%b ready=%b check=%b id0=%h, required 0000/0100/01/%h", rsp_valid_o, req_ready_o, rf_check_o, rf_id_o[0], req_id_i[2]);
        end
        step();
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_i       = ($urandom_range(0, 39) == 0);
            req_valid_i = NR'($urandom);
            rsp_ready_i = NR'($urandom);
            rand_req(); rand_rf();
            #3;
            model_eval();
            n_vec++;
            if ({req_ready_o, rf_check_o, rf_id_o, rf_sd_o} !== {e_ready, e_check, e_rf_id, e_rf_sd}) begin
                n_mis++;
                $display("FAIL rand_port c%0d: got %h, model %h", c, {req_ready_o, rf_check_o, rf_id_o, rf_sd_o}, {e_ready, e_check, e_rf_id, e_rf_sd});
            end
            n_vec++;
            if ({rsp_valid_o, rsp_present_o, rsp_sd_o, rsp_id_err_o, rsp_bypass_o, rsp_ignore_o} !== {m_pend, m_pres, m_sd, m_err, m_byp, m_ign}) begin
                n_mis++;
                $display("FAIL rand_rsp c%0d: got %h, model %h", c, {rsp_valid_o, rsp_present_o, rsp_sd_o, rsp_id_err_o, rsp_bypass_o, rsp_ignore_o}, {m_pend, m_pres, m_sd, m_err, m_byp, m_ign});
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_all_valid();
        test_bypass_ignore();
        test_hold();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
